// File: rtl/his_builder_multi.sv
// Multi-pixel dToF histogram builder with per-pixel peak search.
// Timestamps arrive pixel-interleaved; each one is binned by its MSBs into
// that pixel's saturating histogram. After ACQ_NUM acquisitions every pixel's
// histogram is scanned in parallel, the peaks are published, and the
// histograms are cleared for the next frame.
module his_builder_multi #(
  parameter int NP        = 10,
  parameter int BIN_BITS  = 5,
  parameter int PIXEL_NUM = 3,
  parameter int ACQ_NUM   = 2,
  parameter int CNT_W     = 8,
  parameter int MIN_CNT   = 1
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic                           wrEn,
  input  logic [NP-1:0]                  data,
  output logic                           ready,
  output logic [PIXEL_NUM*BIN_BITS-1:0]  peakResult,
  output logic [PIXEL_NUM*CNT_W-1:0]     peakCnt,
  output logic [PIXEL_NUM-1:0]           peakHit,
  output logic                           done,
  output logic                           dropErr
);

  localparam int NBIN = 2**BIN_BITS;
  localparam int PW   = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
  localparam int AW   = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_THR = CNT_W'(MIN_CNT);

  typedef enum logic [1:0] {ACCUM, SEARCH, DONE} stateT;

  stateT                state;
  logic [CNT_W-1:0]     hist [PIXEL_NUM][NBIN];
  logic [CNT_W-1:0]     maxCnt [PIXEL_NUM];
  logic [BIN_BITS-1:0]  maxBin [PIXEL_NUM];
  logic [PW-1:0]        pixPtr;
  logic [AW-1:0]        acqPtr;
  logic [BIN_BITS:0]    binIdx;
  logic [BIN_BITS-1:0]  wrBin;
  logic [BIN_BITS-1:0]  scanBin;
  logic                 accept;
  logic                 scanOver;
  logic                 unusedLowBits;

  assign wrBin         = data[NP-1 -: BIN_BITS];
  assign unusedLowBits = ^data[NP-BIN_BITS-1:0];
  assign accept        = wrEn & ready;
  assign scanBin       = binIdx[BIN_BITS-1:0];
  // binIdx counts one past the last bin so the final compare lands in
  // maxCnt/maxBin before the outputs are registered from them.
  assign scanOver      = binIdx[BIN_BITS];

  // Histogram accumulation with saturation; cleared on reset and in DONE.
  always_ff @(posedge clk) begin
    if (!res || state == DONE) begin
      for (int unsigned p = 0; p < PIXEL_NUM; p++)
        for (int unsigned b = 0; b < NBIN; b++)
          hist[p][b] <= '0;
    end else if (accept && hist[pixPtr][wrBin] != CNT_MAX) begin
      hist[pixPtr][wrBin] <= hist[pixPtr][wrBin] + CNT_W'(1);
    end
  end

  // Parallel running-maximum scan; strict compare keeps the lowest bin on ties.
  always_ff @(posedge clk) begin
    if (!res || state != SEARCH) begin
      for (int unsigned p = 0; p < PIXEL_NUM; p++) begin
        maxCnt[p] <= '0;
        maxBin[p] <= '0;
      end
    end else if (!scanOver) begin
      for (int unsigned p = 0; p < PIXEL_NUM; p++) begin
        if (hist[p][scanBin] > maxCnt[p]) begin
          maxCnt[p] <= hist[p][scanBin];
          maxBin[p] <= scanBin;
        end
      end
    end
  end

  // Control FSM: pointers, handshake, drop flag and registered peak outputs.
  always_ff @(posedge clk) begin
    if (!res) begin
      state      <= ACCUM;
      ready      <= 1'b1;
      done       <= 1'b0;
      dropErr    <= 1'b0;
      pixPtr     <= '0;
      acqPtr     <= '0;
      binIdx     <= '0;
      peakResult <= '0;
      peakCnt    <= '0;
      peakHit    <= '0;
    end else begin
      done <= 1'b0;
      if (wrEn && !ready)
        dropErr <= 1'b1;
      case (state)
        ACCUM: begin
          if (accept) begin
            if (pixPtr == PW'(PIXEL_NUM - 1)) begin
              pixPtr <= '0;
              if (acqPtr == AW'(ACQ_NUM - 1)) begin
                acqPtr <= '0;
                binIdx <= '0;
                ready  <= 1'b0;
                state  <= SEARCH;
              end else begin
                acqPtr <= acqPtr + AW'(1);
              end
            end else begin
              pixPtr <= pixPtr + PW'(1);
            end
          end
        end
        SEARCH: begin
          if (scanOver) begin
            state <= DONE;
            done  <= 1'b1;
            for (int unsigned p = 0; p < PIXEL_NUM; p++) begin
              if (maxCnt[p] >= MIN_THR) begin
                peakResult[p*BIN_BITS +: BIN_BITS] <= maxBin[p];
                peakCnt[p*CNT_W +: CNT_W]          <= maxCnt[p];
                peakHit[p]                         <= 1'b1;
              end else begin
                peakResult[p*BIN_BITS +: BIN_BITS] <= '0;
                peakCnt[p*CNT_W +: CNT_W]          <= '0;
                peakHit[p]                         <= 1'b0;
              end
            end
          end else begin
            binIdx <= binIdx + (BIN_BITS+1)'(1);
          end
        end
        DONE: begin
          state  <= ACCUM;
          ready  <= 1'b1;
          pixPtr <= '0;
          acqPtr <= '0;
          binIdx <= '0;
        end
        default: begin
          state <= ACCUM;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
